// File: rtl/hazard_pkg.sv
// Shared state encoding and default widths for the pipeline hazard controller.
package hazard_pkg;

  localparam int unsigned DEF_REG_AW = 5;
  localparam int unsigned STATE_W    = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_RUN     = 2'd0,
    ST_MC_WAIT = 2'd1,
    ST_FLUSH   = 2'd2
  } state_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare: the load in EX writes a register the ID instruction reads.
module hazard_detect
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW = DEF_REG_AW
) (
  input  logic [REG_AW-1:0] i_id_r1,
  input  logic [REG_AW-1:0] i_id_r2,
  input  logic [REG_AW-1:0] i_ex_rd,
  input  logic              i_ex_is_load,
  output logic              o_hazard_c
);

  // Register 0 is never a real dependency.
  assign o_hazard_c = i_ex_is_load && (i_ex_rd != '0) &&
                      ((i_ex_rd == i_id_r1) || (i_ex_rd == i_id_r2));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// In-order pipeline stage sequencer: stage enables and bubble controls for
// load-use stalls, multi-cycle EX holds and taken-branch squashes.
// Optional perf counters (stall_cnt, flush_cnt_o) under HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW       = DEF_REG_AW,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned MC_TIMEOUT   = 32
`ifdef HAZARD_PERF_CNT_EN
  ,
  parameter int unsigned CNT_W        = 32
`endif
) (
  input  logic              clk_en,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_r1,
  input  logic [REG_AW-1:0] id_r2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_is_load,
  input  logic              ex_mc_start,
  input  logic              mc_done,
  input  logic              branch_taken,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              id_ex_en,
  output logic              ex_mem_en,
  output logic              if_id_no_output,
  output logic              id_ex_no_output,
  output logic              busy,
  output logic              mc_timeout,
  output logic [STATE_W-1:0] state_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt_o
`endif
);

  localparam int unsigned FL_W = $clog2(FLUSH_CYCLES + 1);
  localparam int unsigned MC_W = $clog2(MC_TIMEOUT + 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [FL_W-1:0] r_flush_cnt;
  logic [FL_W-1:0] w_flush_nxt;
  logic [MC_W-1:0] r_mc_cnt;
  logic [MC_W-1:0] w_mc_nxt;
  logic            r_mc_timeout;
  logic            w_set_timeout;
  logic            w_branch_acc;
  logic            w_hazard;
  logic            w_pc_en;
  logic            w_if_id_en;
  logic            w_id_ex_en;
  logic            w_ex_mem_en;
  logic            w_if_id_no;
  logic            w_id_ex_no;

  hazard_detect #(.REG_AW(REG_AW)) u_detect (
    .i_id_r1      (id_r1),
    .i_id_r2      (id_r2),
    .i_ex_rd      (ex_rd),
    .i_ex_is_load (ex_is_load),
    .o_hazard_c   (w_hazard)
  );

  // Next-state, counter update and Mealy stage-control decode.
  always_comb begin
    w_state_nxt   = r_state;
    w_flush_nxt   = r_flush_cnt;
    w_mc_nxt      = r_mc_cnt;
    w_set_timeout = 1'b0;
    w_branch_acc  = 1'b0;
    w_pc_en       = 1'b1;
    w_if_id_en    = 1'b1;
    w_id_ex_en    = 1'b1;
    w_ex_mem_en   = 1'b1;
    w_if_id_no    = 1'b1;
    w_id_ex_no    = 1'b1;
    unique case (r_state)
      ST_RUN: begin
        if (branch_taken) begin
          w_if_id_no   = 1'b0;
          w_id_ex_no   = 1'b0;
          w_branch_acc = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            w_state_nxt = ST_FLUSH;
            w_flush_nxt = FL_W'(FLUSH_CYCLES - 1);
          end
        end else if (ex_mc_start) begin
          // Result already valid in the start cycle: no wait needed.
          if (!mc_done) begin
            w_state_nxt = ST_MC_WAIT;
            w_mc_nxt    = MC_W'(1);
          end
        end else if (w_hazard) begin
          w_pc_en    = 1'b0;
          w_if_id_en = 1'b0;
          w_id_ex_no = 1'b0;
        end
      end
      ST_MC_WAIT: begin
        w_pc_en     = 1'b0;
        w_if_id_en  = 1'b0;
        w_id_ex_en  = 1'b0;
        w_ex_mem_en = 1'b0;
        if (mc_done) begin
          w_ex_mem_en = 1'b1;
          w_state_nxt = ST_RUN;
          w_mc_nxt    = '0;
        end else if (r_mc_cnt == MC_W'(MC_TIMEOUT)) begin
          w_set_timeout = 1'b1;
          w_id_ex_no    = 1'b0;
          w_state_nxt   = ST_RUN;
          w_mc_nxt      = '0;
        end else begin
          w_mc_nxt = r_mc_cnt + MC_W'(1);
        end
      end
      ST_FLUSH: begin
        w_if_id_no = 1'b0;
        if (branch_taken) begin
          w_id_ex_no   = 1'b0;
          w_branch_acc = 1'b1;
          w_flush_nxt  = FL_W'(FLUSH_CYCLES - 1);
        end else if (r_flush_cnt == FL_W'(1)) begin
          w_state_nxt = ST_RUN;
          w_flush_nxt = '0;
        end else begin
          w_flush_nxt = r_flush_cnt - FL_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
        w_flush_nxt = '0;
        w_mc_nxt    = '0;
      end
    endcase
  end

  // State, counters and sticky timeout flag.
  always_ff @(posedge clk_en or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_RUN;
      r_flush_cnt  <= '0;
      r_mc_cnt     <= '0;
      r_mc_timeout <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_flush_cnt  <= w_flush_nxt;
      r_mc_cnt     <= w_mc_nxt;
      r_mc_timeout <= r_mc_timeout | w_set_timeout;
    end
  end

  // Stage controls are forced low while reset is held.
  assign pc_en           = rst & w_pc_en;
  assign if_id_en        = rst & w_if_id_en;
  assign id_ex_en        = rst & w_id_ex_en;
  assign ex_mem_en       = rst & w_ex_mem_en;
  assign if_id_no_output = rst & w_if_id_no;
  assign id_ex_no_output = rst & w_id_ex_no;
  assign busy            = (r_state != ST_RUN);
  assign mc_timeout      = r_mc_timeout;
  assign state_o         = r_state;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt_o;

  // Saturating stall-cycle and accepted-branch counters.
  always_ff @(posedge clk_en or negedge rst) begin
    if (!rst) begin
      r_stall_cnt   <= '0;
      r_flush_cnt_o <= '0;
    end else begin
      if (!w_pc_en && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_branch_acc && (r_flush_cnt_o != '1)) begin
        r_flush_cnt_o <= r_flush_cnt_o + CNT_W'(1);
      end
    end
  end

  assign stall_cnt   = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt_o;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl (FLUSH_CYCLES=2, MC_TIMEOUT=8).
module tb_pipeline_hazard_ctrl;

  typedef struct packed {
    logic [4:0] r1;
    logic [4:0] r2;
    logic [4:0] rd;
    logic       ld;
    logic       mcs;
    logic       dn;
    logic       br;
  } stim_t;

  // {pc, if_id, id_ex, ex_mem, if_id_no, id_ex_no, busy, mc_timeout, state[1:0]}
  localparam logic [9:0] E_ZERO  = 10'b0000_00_0_0_00;
  localparam logic [9:0] E_RUN   = 10'b1111_11_0_0_00;
  localparam logic [9:0] E_LU    = 10'b0011_10_0_0_00;
  localparam logic [9:0] E_BR    = 10'b1111_00_0_0_00;
  localparam logic [9:0] E_FL    = 10'b1111_01_1_0_10;
  localparam logic [9:0] E_FLBR  = 10'b1111_00_1_0_10;
  localparam logic [9:0] E_MCW   = 10'b0000_11_1_0_01;
  localparam logic [9:0] E_MCD   = 10'b0001_11_1_0_01;
  localparam logic [9:0] E_ABT   = 10'b0000_10_1_0_01;
  localparam logic [9:0] E_RUNTO = 10'b1111_11_0_1_00;
  localparam logic [9:0] E_MCWTO = 10'b0000_11_1_1_01;

  logic       clk_en = 1'b0;
  logic       rst;
  logic [4:0] id_r1, id_r2, ex_rd;
  logic       ex_is_load, ex_mc_start, mc_done, branch_taken;
  logic       pc_en, if_id_en, id_ex_en, ex_mem_en;
  logic       if_id_no_output, id_ex_no_output, busy, mc_timeout;
  logic [1:0] state_o;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt_o;
`endif

  int checks = 0;
  int errors = 0;
  logic [9:0] sb[$];

  always #5 clk_en = ~clk_en;

  pipeline_hazard_ctrl #(
    .REG_AW(5), .FLUSH_CYCLES(2), .MC_TIMEOUT(8)
`ifdef HAZARD_PERF_CNT_EN
    , .CNT_W(32)
`endif
  ) dut (
    .clk_en(clk_en), .rst(rst),
    .id_r1(id_r1), .id_r2(id_r2), .ex_rd(ex_rd),
    .ex_is_load(ex_is_load), .ex_mc_start(ex_mc_start),
    .mc_done(mc_done), .branch_taken(branch_taken),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .if_id_no_output(if_id_no_output), .id_ex_no_output(id_ex_no_output),
    .busy(busy), .mc_timeout(mc_timeout), .state_o(state_o)
`ifdef HAZARD_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt_o(flush_cnt_o)
`endif
  );

  function automatic stim_t st(input logic [4:0] r1, input logic [4:0] r2,
                               input logic [4:0] rd, input logic ld,
                               input logic mcs, input logic dn, input logic br);
    return {r1, r2, rd, ld, mcs, dn, br};
  endfunction

  function automatic logic [9:0] obs();
    return {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_no_output,
            id_ex_no_output, busy, mc_timeout, state_o};
  endfunction

  // Drive one cycle of inputs and record what the controller must show.
  task automatic apply(input stim_t s, input logic [9:0] e);
    id_r1 = s.r1; id_r2 = s.r2; ex_rd = s.rd;
    ex_is_load = s.ld; ex_mc_start = s.mcs; mc_done = s.dn; branch_taken = s.br;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    logic [9:0] got, want;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      apply(st(5'($urandom()), 5'($urandom()), 5'($urandom()), 1'($urandom()),
               1'($urandom()), 1'($urandom()), 1'($urandom())), E_ZERO);
      @(negedge clk_en);
      got = obs(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL reset_hold[%0d] got=%b want=%b", i, got, want);
      end
      @(posedge clk_en); #1;
    end
    rst = 1'b1;
    apply(st(0, 0, 0, 0, 0, 0, 0), E_RUN);
    @(negedge clk_en);
    got = obs(); want = sb.pop_front(); checks++;
    if (got !== want) begin
      errors++; $display("FAIL reset_release got=%b want=%b", got, want);
    end
    @(posedge clk_en); #1;
  endtask

  task automatic test_load_use();
    stim_t s[$]; logic [9:0] e[$]; logic [9:0] got, want;
    s = '{st(3, 5, 5, 1, 0, 0, 0), st(3, 5, 0, 1, 0, 0, 0),
          st(7, 2, 7, 1, 0, 0, 0), st(0, 0, 0, 0, 0, 0, 0),
          st(5, 9, 5, 0, 0, 0, 0), st(0, 4, 0, 1, 0, 0, 0),
          st(31, 31, 31, 1, 0, 0, 0), st(0, 0, 0, 0, 0, 0, 0)};
    e = '{E_LU, E_RUN, E_LU, E_RUN, E_RUN, E_RUN, E_LU, E_RUN};
    foreach (s[i]) begin
      apply(s[i], e[i]);
      @(negedge clk_en);
      got = obs(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL load_use[%0d] got=%b want=%b", i, got, want);
      end
      @(posedge clk_en); #1;
    end
  endtask

  task automatic test_branch();
    stim_t s[$]; logic [9:0] e[$]; logic [9:0] got, want;
    s = '{st(0, 0, 0, 0, 0, 0, 1), st(0, 0, 0, 0, 0, 0, 0), st(0, 0, 0, 0, 0, 0, 0),
          st(0, 0, 0, 0, 0, 0, 1), st(0, 0, 0, 0, 0, 0, 1),
          st(6, 6, 6, 1, 1, 0, 0), st(0, 0, 0, 0, 0, 0, 0)};
    e = '{E_BR, E_FL, E_RUN, E_BR, E_FLBR, E_FL, E_RUN};
    foreach (s[i]) begin
      apply(s[i], e[i]);
      @(negedge clk_en);
      got = obs(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL branch[%0d] got=%b want=%b", i, got, want);
      end
      @(posedge clk_en); #1;
    end
  endtask

  task automatic test_multicycle();
    stim_t s[$]; logic [9:0] e[$]; logic [9:0] got, want;
    s = '{st(0, 0, 0, 0, 1, 0, 0), st(0, 0, 0, 0, 0, 0, 0), st(0, 0, 0, 0, 0, 0, 1),
          st(0, 0, 0, 0, 0, 0, 0), st(0, 0, 0, 0, 0, 1, 0), st(0, 0, 0, 0, 0, 0, 0),
          st(5, 0, 5, 1, 1, 1, 0), st(0, 0, 0, 0, 0, 0, 0),
          st(0, 0, 0, 0, 1, 0, 1), st(0, 0, 0, 0, 0, 0, 0), st(0, 0, 0, 0, 0, 0, 0)};
    e = '{E_RUN, E_MCW, E_MCW, E_MCW, E_MCD, E_RUN,
          E_RUN, E_RUN, E_BR, E_FL, E_RUN};
    foreach (s[i]) begin
      apply(s[i], e[i]);
      @(negedge clk_en);
      got = obs(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL multicycle[%0d] got=%b want=%b", i, got, want);
      end
      @(posedge clk_en); #1;
    end
  endtask

  task automatic test_timeout();
    logic [9:0] got, want;
    for (int i = 0; i < 11; i++) begin
      apply(st(0, 0, 0, 0, (i == 0), 0, 0),
            (i == 0) ? E_RUN : (i < 8) ? E_MCW : (i == 8) ? E_ABT : E_RUNTO);
      @(negedge clk_en);
      got = obs(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL timeout[%0d] got=%b want=%b", i, got, want);
      end
      @(posedge clk_en); #1;
    end
  endtask

  task automatic test_reset_mid_mc();
    logic [9:0] got, want;
    for (int i = 0; i < 2; i++) begin
      apply(st(0, 0, 0, 0, (i == 0), 0, 0), (i == 0) ? E_RUNTO : E_MCWTO);
      @(negedge clk_en);
      got = obs(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++; $display("FAIL mid_rst_pre[%0d] got=%b want=%b", i, got, want);
      end
      if (i == 0) begin
        @(posedge clk_en); #1;
      end
    end
    #2 rst = 1'b0;
    sb.push_back(E_ZERO);
    #1;
    got = obs(); want = sb.pop_front(); checks++;
    if (got !== want) begin
      errors++; $display("FAIL mid_rst_async got=%b want=%b", got, want);
    end
    @(posedge clk_en); #1;
    rst = 1'b1;
    apply(st(0, 0, 0, 0, 0, 0, 0), E_RUN);
    @(negedge clk_en);
    got = obs(); want = sb.pop_front(); checks++;
    if (got !== want) begin
      errors++; $display("FAIL mid_rst_release got=%b want=%b", got, want);
    end
    @(posedge clk_en); #1;
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic test_perf();
    stim_t s[$];
    rst = 1'b0;
    apply(st(0, 0, 0, 0, 0, 0, 0), E_ZERO);
    void'(sb.pop_front());
    @(posedge clk_en); #1;
    rst = 1'b1;
    s = '{st(3, 5, 5, 1, 0, 0, 0), st(0, 0, 0, 0, 0, 0, 0), st(0, 0, 0, 0, 0, 0, 1),
          st(0, 0, 0, 0, 0, 0, 0), st(0, 0, 0, 0, 0, 0, 0)};
    foreach (s[i]) begin
      apply(s[i], E_RUN);
      void'(sb.pop_front());
      @(posedge clk_en); #1;
    end
    @(negedge clk_en);
    checks++;
    if (stall_cnt !== 32'd1) begin
      errors++; $display("FAIL perf_stall got=%0d want=1", stall_cnt);
    end
    checks++;
    if (flush_cnt_o !== 32'd1) begin
      errors++; $display("FAIL perf_flush got=%0d want=1", flush_cnt_o);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    apply(st(0, 0, 0, 0, 0, 0, 0), E_ZERO);
    void'(sb.pop_front());
    #2;
    test_reset();
    test_load_use();
    test_branch();
    test_multicycle();
    test_timeout();
    test_reset_mid_mc();
`ifdef HAZARD_PERF_CNT_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
